banked_sram_ctrl: RTL and testbench

//  Parametrised single-clock successor to the three-clock SRAM emulator. Word = NUM_BANKS

---
 rtl/banked_sram_ctrl_if.sv | 32 +++
 rtl/banked_sram_ctrl.sv | 101 ++++++++++
 tb/tb_banked_sram_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/banked_sram_ctrl_if.sv
// Request/response bundle between a memory-stage master and banked_sram_ctrl.
// The wr_mask signal exists only when SRAM_BANK_MASK_EN is defined.
interface banked_sram_ctrl_if #(
    parameter int AW = 10,
    parameter int BW = 16,
    parameter int NB = 2
);
    localparam int W = NB * BW;

    logic          req;
    logic          rnw;
    logic [AW-1:0] adx_bus;
    logic [W-1:0]  data_in;
`ifdef SRAM_BANK_MASK_EN
    logic [NB-1:0] wr_mask;
`endif
    logic          ready;
    logic          valid;
    logic [W-1:0]  data_out;

`ifdef SRAM_BANK_MASK_EN
    modport master (output req, rnw, adx_bus, data_in, wr_mask,
                    input  ready, valid, data_out);
    modport slave  (input  req, rnw, adx_bus, data_in, wr_mask,
                    output ready, valid, data_out);
`else
    modport master (output req, rnw, adx_bus, data_in,
                    input  ready, valid, data_out);
    modport slave  (input  req, rnw, adx_bus, data_in,
                    output ready, valid, data_out);
`endif
endinterface

// File: rtl/banked_sram_ctrl.sv
// Banked single-port SRAM controller: IDLE -> ACCESS -> DONE, one access per 3 cycles.
// Optional per-bank write mask enabled by defining SRAM_BANK_MASK_EN.
module banked_sram_ctrl #(
    parameter int BANK_WIDTH = 16,
    parameter int NUM_BANKS  = 2,
    parameter int DEPTH      = 1024
) (
    input  logic            clk,
    input  logic            rst,
    banked_sram_ctrl_if.slave bus
);
    localparam int W    = NUM_BANKS * BANK_WIDTH;
    localparam int AW   = $clog2(DEPTH);
    localparam int BSEL = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   mar;
    logic [W-1:0]    mdr;
    logic            op;
    logic            valid_q;
    logic [W-1:0]    dout_q;
`ifdef SRAM_BANK_MASK_EN
    logic [NUM_BANKS-1:0] mask;
`endif

    // Bank b of word a sits at b*DEPTH + a; DEPTH is a power of two so that is {b, a}.
    logic [BANK_WIDTH-1:0] mem [NUM_BANKS*DEPTH];
    logic [W-1:0]          rd_word;

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            rd_word[b*BANK_WIDTH +: BANK_WIDTH] = mem[{BSEL'(b), mar}];
    end

    // Array is not reset; a reset held across the ACCESS edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && !op) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef SRAM_BANK_MASK_EN
                if (mask[b])
                    mem[{BSEL'(b), mar}] <= mdr[b*BANK_WIDTH +: BANK_WIDTH];
`else
                mem[{BSEL'(b), mar}] <= mdr[b*BANK_WIDTH +: BANK_WIDTH];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            op      <= 1'b1;
            valid_q <= 1'b0;
            dout_q  <= '0;
`ifdef SRAM_BANK_MASK_EN
            mask    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        mar <= bus.adx_bus;
                        op  <= bus.rnw;
                        if (!bus.rnw)
                            mdr <= bus.data_in;
`ifdef SRAM_BANK_MASK_EN
                        mask <= bus.wr_mask;
`endif
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read data is presented together with the Valid pulse.
                    if (op) begin
                        mdr    <= rd_word;
                        dout_q <= rd_word;
                    end
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.valid    = valid_q;
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Directed, table-driven bench for banked_sram_ctrl (default 2x16-bit banks, 1024 words).
module tb_banked_sram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    banked_sram_ctrl_if #(.AW(10), .BW(16), .NB(2)) bus ();

    banked_sram_ctrl #(.BANK_WIDTH(16), .NUM_BANKS(2), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk)
        if (!rst && bus.req === 1'b1 && bus.ready === 1'b1)
            assert (!$isunknown(bus.rnw)) else $error("protocol error: rnw unknown with req");

    typedef struct {
        logic        rnw;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [1:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_timeout: got %b expected 1", name, bus.ready);
        end
    endtask

    task automatic drive(input logic rnw, input logic [9:0] addr, input logic [31:0] data,
                         input logic [1:0] mask);
        bus.req     = 1'b1;
        bus.rnw     = rnw;
        bus.adx_bus = addr;
        bus.data_in = data;
`ifdef SRAM_BANK_MASK_EN
        bus.wr_mask = mask;
`else
        if (mask === 2'bxx) bus.req = 1'b1;
`endif
    endtask

    task automatic do_op(input string name, input logic rnw, input logic [9:0] addr,
                         input logic [31:0] data, input logic [1:0] mask, input logic [31:0] exp);
        wait_ready(name);
        drive(rnw, addr, data, mask);
        @(posedge clk); #1;
        bus.req = 1'b0;
        chk({name, "_e0_ready"}, {31'd0, bus.ready}, 32'd0);
        chk({name, "_e0_valid"}, {31'd0, bus.valid}, 32'd0);
        @(posedge clk); #1;
        chk({name, "_e1_valid"}, {31'd0, bus.valid}, 32'd1);
        if (rnw) begin
            chk({name, "_rdata"}, bus.data_out, exp);
            last_rd = exp;
        end else begin
            chk({name, "_dout_kept"}, bus.data_out, last_rd);
        end
        @(posedge clk); #1;
        chk({name, "_e2_valid"}, {31'd0, bus.valid}, 32'd0);
        chk({name, "_e2_ready"}, {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 10'h005, 32'hDEADBEEF, 2'b11, 32'h0};
        vecs[1]  = '{1'b1, 10'h005, 32'h0,        2'b11, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 10'h3FF, 32'h11112222, 2'b11, 32'h0};
        vecs[3]  = '{1'b0, 10'h000, 32'h33334444, 2'b11, 32'h0};
        vecs[4]  = '{1'b1, 10'h3FF, 32'h0,        2'b11, 32'h11112222};
        vecs[5]  = '{1'b1, 10'h000, 32'h0,        2'b11, 32'h33334444};
        vecs[6]  = '{1'b0, 10'h007, 32'hAAAABBBB, 2'b11, 32'h0};
        vecs[7]  = '{1'b0, 10'h007, 32'hCCCCDDDD, 2'b01, 32'h0};
`ifdef SRAM_BANK_MASK_EN
        vecs[8]  = '{1'b1, 10'h007, 32'h0,        2'b11, 32'hAAAADDDD};
`else
        vecs[8]  = '{1'b1, 10'h007, 32'h0,        2'b11, 32'hCCCCDDDD};
`endif
        vecs[9]  = '{1'b0, 10'h009, 32'h00000000, 2'b11, 32'h0};
        vecs[10] = '{1'b1, 10'h009, 32'h0,        2'b11, 32'h00000000};

        bus.req     = 1'b0;
        bus.rnw     = 1'b1;
        bus.adx_bus = '0;
        bus.data_in = '0;
`ifdef SRAM_BANK_MASK_EN
        bus.wr_mask = '0;
`endif

        #1 rst = 1'b1;
        #2;
        chk("reset_ready", {31'd0, bus.ready}, 32'd1);
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_dout",  bus.data_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].data,
                  vecs[i].mask, vecs[i].exp);

        // Reset during DONE: write already committed, Valid and DataOut cleared at once.
        do_op("rd3ff", 1'b1, 10'h3FF, 32'h0, 2'b11, 32'h11112222);
        wait_ready("commit");
        drive(1'b0, 10'h00A, 32'h5A5A5A5A, 2'b11);
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #2;
        chk("commit_pre_valid", {31'd0, bus.valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, bus.valid}, 32'd0);
        chk("async_ready", {31'd0, bus.ready}, 32'd1);
        chk("async_dout",  bus.data_out, 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        do_op("commit_rd", 1'b1, 10'h00A, 32'h0, 2'b11, 32'h5A5A5A5A);

        // Reset during ACCESS: write dropped, no Valid pulse.
        wait_ready("drop");
        drive(1'b0, 10'h009, 32'hFFFF0000, 2'b11);
        @(posedge clk); #1;
        bus.req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("drop_valid0", {31'd0, bus.valid}, 32'd0);
        chk("drop_ready0", {31'd0, bus.ready}, 32'd1);
        last_rd = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) rst = 1'b0;
            chk($sformatf("drop_valid_c%0d", k), {31'd0, bus.valid}, 32'd0);
        end
        do_op("drop_rd", 1'b1, 10'h009, 32'h0, 2'b11, 32'h00000000);

        // Req held across three reads: accepts at edges 1,4,7.
        wait_ready("held");
        drive(1'b1, 10'h3FF, 32'h0, 2'b11);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held_valid_e%0d", k), {31'd0, bus.valid},
                (k % 3 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("held_ready_e%0d", k), {31'd0, bus.ready},
                (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 2)
                chk($sformatf("held_data_e%0d", k), bus.data_out, 32'h11112222);
            if (k == 9) bus.req = 1'b0;
        end
        @(posedge clk); #1;
        chk("held_stop_ready", {31'd0, bus.ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
